// File: rtl/memory_arbiter.sv
// Two-port memory arbiter: a CPU and a programmer share one synchronous memory.
// Round-robin tie-break; prog_lock fences off new CPU grants during programming.
module memory_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              prog_lock,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_adrs,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              prg_req,
   input  logic              prg_we,
   input  logic [ADDR_W-1:0] prg_adrs,
   input  logic [DATA_W-1:0] prg_wdata,
   output logic              prg_ack,
   output logic [DATA_W-1:0] prg_rdata,
   output logic              mm_wr_en,
   output logic [ADDR_W-1:0] mm_adrs,
   output logic [DATA_W-1:0] mm_code,
   input  logic [DATA_W-1:0] mm_data,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

   state_t              state_q, state_d;
   logic                last_grant_q, last_grant_d;   // 1 = programmer owns/owned the access
   logic                mm_wr_en_q, mm_wr_en_d;
   logic [ADDR_W-1:0]   mm_adrs_q, mm_adrs_d;
   logic [DATA_W-1:0]   mm_code_q, mm_code_d;
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0]   prg_rdata_q, prg_rdata_d;
   logic                cpu_elig;
   logic                grant_prg;

   assign cpu_elig = cpu_req & ~prog_lock;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         mm_wr_en_q   <= 1'b0;
         mm_adrs_q    <= '0;
         mm_code_q    <= '0;
         cpu_rdata_q  <= '0;
         prg_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         mm_wr_en_q   <= mm_wr_en_d;
         mm_adrs_q    <= mm_adrs_d;
         mm_code_q    <= mm_code_d;
         cpu_rdata_q  <= cpu_rdata_d;
         prg_rdata_q  <= prg_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      mm_wr_en_d   = 1'b0;
      mm_adrs_d    = mm_adrs_q;
      mm_code_d    = mm_code_q;
      cpu_rdata_d  = cpu_rdata_q;
      prg_rdata_d  = prg_rdata_q;
      grant_prg    = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_elig || prg_req) begin
               // On a tie the programmer wins only if the CPU had the previous grant.
               grant_prg    = prg_req && (!cpu_elig || !last_grant_q);
               state_d      = ACCESS;
               last_grant_d = grant_prg;
               mm_wr_en_d   = grant_prg ? prg_we    : cpu_we;
               mm_adrs_d    = grant_prg ? prg_adrs  : cpu_adrs;
               mm_code_d    = grant_prg ? prg_wdata : cpu_wdata;
            end
         end
         ACCESS: begin
            state_d = mm_wr_en_q ? DONE : CAPTURE;
         end
         CAPTURE: begin
            if (last_grant_q) prg_rdata_d = mm_data;
            else              cpu_rdata_d = mm_data;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign cpu_ack   = (state_q == DONE) && !last_grant_q;
   assign prg_ack   = (state_q == DONE) &&  last_grant_q;
   assign busy      = (state_q != IDLE);
   assign mm_wr_en  = mm_wr_en_q;
   assign mm_adrs   = mm_adrs_q;
   assign mm_code   = mm_code_q;
   assign cpu_rdata = cpu_rdata_q;
   assign prg_rdata = prg_rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed scoreboard bench for memory_arbiter with a one-cycle-latency memory model.
module tb_memory_arbiter;

   logic       clock = 1'b0;
   logic       reset;
   logic       prog_lock;
   logic       cpu_req, cpu_we;
   logic [7:0] cpu_adrs, cpu_wdata;
   logic       cpu_ack;
   logic [7:0] cpu_rdata;
   logic       prg_req, prg_we;
   logic [7:0] prg_adrs, prg_wdata;
   logic       prg_ack;
   logic [7:0] prg_rdata;
   logic       mm_wr_en;
   logic [7:0] mm_adrs, mm_code;
   logic [7:0] mm_data;
   logic       busy;

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit         who;     // 1 = programmer
      bit         we;
      logic [7:0] adrs;
      logic [7:0] wdata;
      logic [7:0] rdata;
   } exp_t;

   exp_t sbq[$];

   logic [7:0] mem [256] = '{default: 8'h00};

   memory_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
      .clock(clock), .reset(reset), .prog_lock(prog_lock),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adrs(cpu_adrs), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .prg_req(prg_req), .prg_we(prg_we), .prg_adrs(prg_adrs), .prg_wdata(prg_wdata),
      .prg_ack(prg_ack), .prg_rdata(prg_rdata),
      .mm_wr_en(mm_wr_en), .mm_adrs(mm_adrs), .mm_code(mm_code), .mm_data(mm_data),
      .busy(busy)
   );

   always #5 clock = ~clock;

   // Synchronous memory: read data appears one cycle after the address.
   always @(posedge clock) begin
      if (mm_wr_en) mem[mm_adrs] <= mm_code;
      mm_data <= mem[mm_adrs];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int count_who(input bit w);
      int c = 0;
      foreach (sbq[i]) if (sbq[i].who == w) c++;
      return c;
   endfunction

   task automatic start_access(input bit who, input bit we, input logic [7:0] adrs,
                               input logic [7:0] wdata, input logic [7:0] rdata);
      exp_t e;
      @(negedge clock);
      if (who) begin
         prg_req = 1'b1; prg_we = we; prg_adrs = adrs; prg_wdata = wdata;
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_adrs = adrs; cpu_wdata = wdata;
      end
      e.who = who; e.we = we; e.adrs = adrs; e.wdata = wdata; e.rdata = rdata;
      sbq.push_back(e);
   endtask

   // Expects the next rising edge to be the grant edge of the oldest queued access.
   task automatic finish_access(input bit lock_mid);
      exp_t e;
      int   n;
      bit   got;
      e = sbq[0];
      @(posedge clock); #1;
      chk("busy_after_grant", 32'(busy), 32'd1);
      chk("wr_en_in_access", 32'(mm_wr_en), 32'(e.we));
      chk("mm_adrs", 32'(mm_adrs), 32'(e.adrs));
      if (e.we) chk("mm_code", 32'(mm_code), 32'(e.wdata));
      if (lock_mid) prog_lock = 1'b1;
      n = 0;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clock); #1;
         n++;
         if (cpu_ack || prg_ack) got = 1'b1;
      end
      chk("ack_seen", 32'(got), 32'd1);
      e = sbq.pop_front();
      if (got) begin
         chk("ack_owner", 32'(prg_ack), 32'(e.who));
         chk("ack_latency", 32'(n), e.we ? 32'd1 : 32'd2);
         chk("wr_en_dropped", 32'(mm_wr_en), 32'd0);
         if (!e.we) chk("rdata", 32'(e.who ? prg_rdata : cpu_rdata), 32'(e.rdata));
      end
      @(posedge clock); #1;
      cpu_req = 1'b0;
      prg_req = 1'b0;
      chk("ack_one_cycle", 32'({cpu_ack, prg_ack}), 32'd0);
      chk("busy_back_idle", 32'(busy), 32'd0);
   endtask

   // Both requesters compete; each re-requests after its ack while it still has queued work.
   task automatic run_contention(input int budget);
      bit   cpu_drop = 1'b0;
      bit   prg_drop = 1'b0;
      bit   done = 1'b0;
      exp_t e;
      for (int i = 0; i < budget && !done; i++) begin
         @(posedge clock); #1;
         if (cpu_drop) begin cpu_req = 1'b0; cpu_drop = 1'b0; end
         if (prg_drop) begin prg_req = 1'b0; prg_drop = 1'b0; end
         if (cpu_ack || prg_ack) begin
            if (sbq.size() == 0) begin
               chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("grant_order", 32'(prg_ack), 32'(e.who));
            end
            if (cpu_ack) cpu_drop = 1'b1;
            if (prg_ack) prg_drop = 1'b1;
         end
         if (sbq.size() == 0 && !cpu_drop && !prg_drop) done = 1'b1;
         @(negedge clock);
         if (!cpu_req && !cpu_drop && count_who(1'b0) > 0) cpu_req = 1'b1;
         if (!prg_req && !prg_drop && count_who(1'b1) > 0) prg_req = 1'b1;
      end
      chk("contention_done", 32'(done), 32'd1);
      sbq.delete();
   endtask

   initial begin
      reset = 1'b1; prog_lock = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_adrs = '0; cpu_wdata = '0;
      prg_req = 1'b0; prg_we = 1'b0; prg_adrs = '0; prg_wdata = '0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
      chk("rst_prg_ack", 32'(prg_ack), 32'd0);
      chk("rst_wr_en", 32'(mm_wr_en), 32'd0);
      chk("rst_adrs", 32'(mm_adrs), 32'd0);
      chk("rst_code", 32'(mm_code), 32'd0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      chk("rst_prg_rdata", 32'(prg_rdata), 32'd0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Programmer writes, CPU reads back, programmer reads back
      start_access(1'b1, 1'b1, 8'h10, 8'hA5, 8'h00);
      finish_access(1'b0);
      chk("mem_10", 32'(mem[8'h10]), 32'hA5);
      start_access(1'b1, 1'b1, 8'h20, 8'h3C, 8'h00);
      finish_access(1'b0);
      start_access(1'b0, 1'b0, 8'h20, 8'h00, 8'h3C);
      finish_access(1'b0);
      chk("prg_rdata_held", 32'(prg_rdata), 32'd0);
      start_access(1'b1, 1'b0, 8'h10, 8'h00, 8'hA5);
      finish_access(1'b0);
      chk("cpu_rdata_held", 32'(cpu_rdata), 32'h3C);
      start_access(1'b0, 1'b1, 8'h44, 8'h5A, 8'h00);
      finish_access(1'b0);
      chk("cpu_rdata_after_write", 32'(cpu_rdata), 32'h3C);
      chk("mem_44", 32'(mem[8'h44]), 32'h5A);

      // Ties after a fresh reset alternate starting with the CPU
      @(negedge clock); reset = 1'b1;
      @(negedge clock); reset = 1'b0;
      sbq.push_back('{who: 1'b0, we: 1'b1, adrs: 8'h50, wdata: 8'h01, rdata: 8'h00});
      sbq.push_back('{who: 1'b1, we: 1'b1, adrs: 8'h60, wdata: 8'h02, rdata: 8'h00});
      sbq.push_back('{who: 1'b0, we: 1'b1, adrs: 8'h50, wdata: 8'h01, rdata: 8'h00});
      sbq.push_back('{who: 1'b1, we: 1'b1, adrs: 8'h60, wdata: 8'h02, rdata: 8'h00});
      cpu_we = 1'b1; cpu_adrs = 8'h50; cpu_wdata = 8'h01;
      prg_we = 1'b1; prg_adrs = 8'h60; prg_wdata = 8'h02;
      cpu_req = 1'b1; prg_req = 1'b1;
      run_contention(60);
      chk("tie_mem_60", 32'(mem[8'h60]), 32'h02);

      // prog_lock keeps the CPU out while the programmer is served repeatedly
      @(negedge clock);
      prog_lock = 1'b1;
      sbq.push_back('{who: 1'b1, we: 1'b1, adrs: 8'h60, wdata: 8'h02, rdata: 8'h00});
      sbq.push_back('{who: 1'b1, we: 1'b1, adrs: 8'h60, wdata: 8'h02, rdata: 8'h00});
      sbq.push_back('{who: 1'b1, we: 1'b1, adrs: 8'h60, wdata: 8'h02, rdata: 8'h00});
      cpu_req = 1'b1; prg_req = 1'b1;
      run_contention(60);
      repeat (3) @(posedge clock);
      #1 chk("locked_cpu_idle", 32'(busy), 32'd0);
      @(negedge clock);
      cpu_req = 1'b0;
      prog_lock = 1'b0;

      // Lock raised while a CPU read is in flight still completes it
      start_access(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
      finish_access(1'b1);
      @(negedge clock);
      prog_lock = 1'b0;

      // Reset during a write's ACCESS cycle abandons it; held request is served after release
      start_access(1'b1, 1'b1, 8'h30, 8'h77, 8'h00);
      @(posedge clock); #1;
      chk("abort_wr_en_before", 32'(mm_wr_en), 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("abort_wr_en", 32'(mm_wr_en), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ack", 32'({cpu_ack, prg_ack}), 32'd0);
      @(posedge clock); #1;
      chk("abort_no_ack", 32'({cpu_ack, prg_ack}), 32'd0);
      chk("abort_no_write", 32'(mem[8'h30]), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      finish_access(1'b0);
      chk("resume_write", 32'(mem[8'h30]), 32'h77);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the memory data width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, on ports clock and reset.
REQ-004 The ports SHALL be, name  direction  width  meaning:
- clock  in  1  sole clock; all state changes on its rising edge
- reset  in  1  asynchronous active-high reset
- prog_lock  in  1  programming mode; blocks new CPU grants
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  CPU write (1) or read (0)
- cpu_adrs  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse to CPU
- cpu_rdata  out  DATA_W  last CPU read result
- prg_req  in  1  programmer access request; held until prg_ack
- prg_we  in  1  programmer write (1) or read (0)
- prg_adrs  in  ADDR_W  programmer address
- prg_wdata  in  DATA_W  programmer write data
- prg_ack  out  1  one-cycle completion pulse to programmer
- prg_rdata  out  DATA_W  last programmer read result
- mm_wr_en  out  1  memory write enable, registered
- mm_adrs  out  ADDR_W  memory address, registered
- mm_code  out  DATA_W  memory write data, registered
- mm_data  in  DATA_W  memory read data, valid one cycle after mm_adrs
- busy  out  1  high in every state except IDLE

Function
REQ-005 The block SHALL implement states IDLE, ACCESS, CAPTURE and DONE.
REQ-006 In IDLE the block SHALL sample requests at each rising edge. A request from a single eligible requester SHALL win outright.
REQ-007 When both requesters are eligible, the block SHALL grant the requester that did not receive the previous grant (round-robin). A last_grant flag SHALL record the winner.
REQ-008 While prog_lock=1, cpu_req SHALL be ineligible. An access already granted to the CPU SHALL complete normally.
REQ-009 On a grant, the block SHALL enter ACCESS and register the winner's fields: mm_adrs from adrs, mm_code from wdata, and mm_wr_en from we.
REQ-010 From ACCESS:
- a write SHALL go to DONE, with mm_wr_en dropped to 0;
- a read SHALL go to CAPTURE.
REQ-011 In CAPTURE the block SHALL register mm_data into the winner's rdata register, then go to DONE.
REQ-012 In DONE the block SHALL assert the winner's ack for exactly one cycle, then return to IDLE.
REQ-013 Latency from the grant edge k SHALL be:
- write: ack high in cycle k+2;
- read: ack high in cycle k+3, with rdata already valid in that cycle.
REQ-014 Requesters SHALL hold req, we, adrs and wdata stable until ack and drop req on the edge ending the ack cycle. Because DONE always returns through IDLE, the block SHALL never grant twice for one request.
REQ-015 cpu_rdata and prg_rdata SHALL change only on a completed read for that requester and SHALL otherwise hold their value.
REQ-016 mm_wr_en SHALL be high only during ACCESS of a write, for exactly one cycle per write.
REQ-017 Address and data SHALL pass through unmodified; there is no width conversion and no address arithmetic.
REQ-018 A req deasserted before ack (protocol violation) SHALL NOT abort the access, which SHALL complete to DONE.

Reset
REQ-019 While reset=1, asynchronously:
- state=IDLE;
- mm_wr_en=0, mm_adrs=0, mm_code=0;
- cpu_ack=0, prg_ack=0;
- cpu_rdata=0, prg_rdata=0;
- busy=0;
- last_grant=programmer, so the CPU wins the first tie.
REQ-020 Reset asserted mid-access SHALL abandon the access with no ack and no further write. After release, the block SHALL resume in IDLE on the next rising edge.

Verification
REQ-021 Programmer write: prg_req=1, prg_we=1, prg_adrs=0x10, prg_wdata=0xA5 granted at edge k -> mm_wr_en=1, mm_adrs=0x10 and mm_code=0xA5 in cycle k+1 only; prg_ack pulse in cycle k+2.
REQ-022 CPU read: memory holds 0x3C at 0x20; cpu read at 0x20 -> cpu_ack in cycle k+3 with cpu_rdata=0x3C; prg_rdata unchanged.
REQ-023 Tie after reset: both req raised together -> CPU granted first, then the programmer; repeated ties alternate CPU, PRG, CPU.
REQ-024 prog_lock=1 with both requesting -> only the programmer is granted, repeatedly. With prog_lock raised during an in-flight CPU access -> that access still acks.
REQ-025 Reset raised during ACCESS of a write -> mm_wr_en=0 immediately, no ack, busy=0. Reset released with prg_req held -> normal grant and ack.
